// File: rtl/boundary_feeder_pkg.sv
// Shared types, register map and row validation for the boundary feeder.
// row_legal is only used by the top when BOUNDARY_CHECK_EN is defined.
package boundary_feeder_pkg;

   typedef struct packed {
      logic [9:0] b1;
      logic [9:0] b2;
      logic [9:0] b3;
      logic [9:0] b4;
   } boundary_row_t;

   localparam logic [2:0] REG_B1     = 3'd0;
   localparam logic [2:0] REG_B2     = 3'd1;
   localparam logic [2:0] REG_B3     = 3'd2;
   localparam logic [2:0] REG_B4     = 3'd3;
   localparam logic [2:0] REG_COMMIT = 3'd4;
   localparam logic [2:0] REG_CLR    = 3'd5;
   localparam logic [2:0] REG_RPF    = 3'd6;
   localparam logic [2:0] REG_STATUS = 3'd0;
   localparam logic [2:0] REG_COUNT  = 3'd1;

   localparam logic [9:0] SCREEN_W = 10'd320;

   typedef enum logic [1:0] {IDLE, POP, SHIFT, GAP} feeder_state_t;

   // Two-boundary rows leave b3/b4 at zero; otherwise all four must ascend.
   function automatic logic row_legal(input boundary_row_t r);
      logic in_range;
      logic ordered;
      in_range = (r.b1 < SCREEN_W) && (r.b2 < SCREEN_W) &&
                 (r.b3 < SCREEN_W) && (r.b4 < SCREEN_W);
      ordered  = (r.b1 < r.b2) &&
                 (((r.b3 == 10'd0) && (r.b4 == 10'd0)) ||
                  ((r.b2 < r.b3) && (r.b3 < r.b4)));
      return in_range && ordered;
   endfunction

endpackage

// File: rtl/boundary_feeder_fifo.sv
// Synchronous row FIFO; a push is accepted while full if a pop happens in the
// same cycle, so the count stays put.
module boundary_fifo
   import boundary_feeder_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push_i,
   input  boundary_row_t            wdata_i,
   input  logic                     pop_i,
   output boundary_row_t            rdata_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];
   localparam logic [AW:0]   CNT_ONE  = 1;
   localparam logic [AW-1:0] PTR_ONE  = 1;

   boundary_row_t   mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [AW:0]     count_q;
   logic            do_push, do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == FULL_CNT);
   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);
   assign rdata_o = mem_q[rd_ptr_q];
   assign count_o = count_q;

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CNT_ONE;
            2'b01:   count_q <= count_q - CNT_ONE;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/boundary_feeder.sv
// Buffers software-written boundary rows and pushes a programmable number per
// frame at the start of vertical blanking. BOUNDARY_CHECK_EN enables row checks.
module boundary_feeder
   import boundary_feeder_pkg::*;
#(
   parameter int DEPTH   = 16,
   parameter int VACTIVE = 480
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          chipselect,
   input  logic          write,
   input  logic          read,
   input  logic [2:0]    address,
   input  logic [15:0]   writedata,
   output logic [15:0]   readdata,
   input  logic [9:0]    vcount,
   output logic          shift,
   output logic [39:0]   datain,
   output feeder_state_t state_o
);

   localparam int CW = $clog2(DEPTH) + 1;

   boundary_row_t stage_q, stage_d;
   logic [2:0]    rpf_q, rpf_d;
   logic          ovf_q, ovf_d, unf_q, unf_d, err_q, err_d;
   logic          vhit_q, frame_evt_q;

   feeder_state_t state_q;
   logic [2:0]    remaining_q;
   logic          shift_q;
   boundary_row_t datain_q, last_row_q;

   logic          wr, commit, row_ok, push, pop;
   logic          ovf_set, unf_set, err_set;
   logic [2:0]    clr;
   boundary_row_t head;
   logic          full, empty;
   logic [CW-1:0] fifo_count;
   logic [15:0]   count_ext;
   logic [2:0]    cnt_sat;
   logic          unused_ok;

   assign unused_ok = &{1'b0, read, writedata[15:10]};

   assign wr     = chipselect & write;
   assign commit = wr && (address == REG_COMMIT);
`ifdef BOUNDARY_CHECK_EN
   assign row_ok  = row_legal(stage_q);
   assign err_set = commit & ~row_ok;
`else
   assign row_ok  = 1'b1;
   assign err_set = 1'b0;
`endif
   assign push    = commit & row_ok;
   assign pop     = (state_q == POP) & ~empty;
   assign ovf_set = push & full & ~pop;
   assign unf_set = (state_q == POP) & empty;

   boundary_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (push),
      .wdata_i (stage_q),
      .pop_i   (pop),
      .rdata_o (head),
      .full_o  (full),
      .empty_o (empty),
      .count_o (fifo_count)
   );

   always_comb begin
      stage_d = stage_q;
      rpf_d   = rpf_q;
      clr     = 3'b000;
      if (wr) begin
         case (address)
            REG_B1:  stage_d.b1 = writedata[9:0];
            REG_B2:  stage_d.b2 = writedata[9:0];
            REG_B3:  stage_d.b3 = writedata[9:0];
            REG_B4:  stage_d.b4 = writedata[9:0];
            REG_CLR: clr        = writedata[2:0];
            REG_RPF: rpf_d      = writedata[2:0];
            default: ;
         endcase
      end
      // A set in the same cycle as its clear wins.
      ovf_d = (ovf_q & ~clr[0]) | ovf_set;
      unf_d = (unf_q & ~clr[1]) | unf_set;
      err_d = (err_q & ~clr[2]) | err_set;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stage_q     <= '0;
         rpf_q       <= 3'd1;
         ovf_q       <= 1'b0;
         unf_q       <= 1'b0;
         err_q       <= 1'b0;
         vhit_q      <= 1'b0;
         frame_evt_q <= 1'b0;
      end else begin
         stage_q     <= stage_d;
         rpf_q       <= rpf_d;
         ovf_q       <= ovf_d;
         unf_q       <= unf_d;
         err_q       <= err_d;
         vhit_q      <= (vcount == 10'(VACTIVE));
         frame_evt_q <= (vcount == 10'(VACTIVE)) & ~vhit_q;
      end
   end

   // On underflow the previous row is shifted again so scroll speed stays fixed.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         remaining_q <= 3'd0;
         shift_q     <= 1'b0;
         datain_q    <= '0;
         last_row_q  <= '0;
      end else begin
         shift_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (frame_evt_q && (rpf_q != 3'd0)) begin
                  remaining_q <= rpf_q;
                  state_q     <= POP;
               end
            end
            POP: begin
               if (!empty) begin
                  last_row_q <= head;
                  datain_q   <= head;
               end else begin
                  datain_q   <= last_row_q;
               end
               shift_q <= 1'b1;
               state_q <= SHIFT;
            end
            SHIFT: begin
               remaining_q <= remaining_q - 3'd1;
               state_q     <= GAP;
            end
            GAP:     state_q <= (remaining_q != 3'd0) ? POP : IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   always_comb begin
      count_ext = 16'(fifo_count);
      cnt_sat   = (count_ext > 16'd7) ? 3'd7 : count_ext[2:0];
      case (address)
         REG_STATUS: readdata = {10'b0, err_q, unf_q, ovf_q, cnt_sat};
         REG_COUNT:  readdata = count_ext;
         REG_RPF:    readdata = {13'b0, rpf_q};
         default:    readdata = 16'h0000;
      endcase
   end

   assign shift   = shift_q;
   assign datain  = datain_q;
   assign state_o = state_q;

endmodule
